sp_req_scheduler: RTL and testbench

- Sits between the execute-stage matrix load/store FU and GEMM FU and the scratchpad request FIFO.
- Arbitrates between the two requesters and packs the winner into the scratchpad FIFO word format.
- Tracks outstanding scratchpad operations and blocks issue on matrix-register hazards: RAW, WAW and store-after-pending-write.
- Reports drain status so halt can wait for all scratchpad traffic to retire.

---
 rtl/sp_req_scheduler.sv | 131 +++++++++++++
 tb/tb_sp_req_scheduler.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sp_req_scheduler.sv
// Scratchpad request scheduler: arbitrates matrix load/store and GEMM requests,
// blocks matrix-register hazards, tracks in-flight ops and reports drain status.
module sp_req_scheduler #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int NUM_MAT         = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        mls_valid,
    input  logic        mls_is_store,
    input  logic [3:0]  mls_rd,
    input  logic [31:0] mls_addr,
    output logic        mls_ready,
    input  logic        gemm_valid,
    input  logic        gemm_new_weight,
    input  logic [3:0]  gemm_rs1,
    input  logic [3:0]  gemm_rs2,
    input  logic [3:0]  gemm_rs3,
    input  logic [3:0]  gemm_rd,
    output logic        gemm_ready,
    input  logic        fifo_full,
    output logic        fifo_wen,
    output logic [37:0] fifo_wdata,
    input  logic        load_complete,
    input  logic        store_complete,
    input  logic        gemm_complete,
    input  logic [3:0]  load_complete_rd,
    input  logic [3:0]  gemm_complete_rd,
    input  logic        halt,
    output logic        drained
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    logic [NUM_MAT-1:0] r_pendingWr;
    logic [CW-1:0]      r_ldCnt, r_stCnt, r_gmCnt;
    logic               r_rrPrio;
    logic               r_fifoWen;
    logic [37:0]        r_fifoWdata;
    logic               r_drained;

    logic               w_mlsElig, w_gemmElig, w_canGrant;
    logic               w_mlsCand, w_gemmCand;
    logic               w_grantMls, w_grantGemm;
    logic               w_ldAcc, w_stAcc;
    logic [CW-1:0]      w_ldCntNext, w_stCntNext, w_gmCntNext;
    logic [NUM_MAT-1:0] w_set, w_clr;
    logic [37:0]        w_mlsWord, w_gemmWord;

    // A retire pulse at zero count is ignored; inc and dec together cancel.
    function automatic logic [CW-1:0] nextCount(input logic [CW-1:0] cnt,
                                                input logic inc, input logic dec);
        logic decEff;
        decEff = dec && (cnt != '0);
        if (inc && !decEff)
            nextCount = cnt + CW'(1);
        else if (!inc && decEff)
            nextCount = cnt - CW'(1);
        else
            nextCount = cnt;
    endfunction

    always_comb begin
        w_mlsElig  = !r_pendingWr[mls_rd] &&
                     (mls_is_store ? (r_stCnt < MAX_CNT) : (r_ldCnt < MAX_CNT));
        w_gemmElig = !r_pendingWr[gemm_rs1] && !r_pendingWr[gemm_rs2] &&
                     !r_pendingWr[gemm_rs3] && !r_pendingWr[gemm_rd] &&
                     (r_gmCnt < MAX_CNT);
        // Reset also suppresses grants so nothing is acknowledged that will be forgotten.
        w_canGrant  = !halt && !fifo_full && !RST;
        w_mlsCand   = mls_valid && w_mlsElig;
        w_gemmCand  = gemm_valid && w_gemmElig;
        w_grantMls  = w_canGrant && w_mlsCand && (!w_gemmCand || !r_rrPrio);
        w_grantGemm = w_canGrant && w_gemmCand && (!w_mlsCand || r_rrPrio);
        w_ldAcc     = w_grantMls && !mls_is_store;
        w_stAcc     = w_grantMls && mls_is_store;
        w_ldCntNext = nextCount(r_ldCnt, w_ldAcc, load_complete);
        w_stCntNext = nextCount(r_stCnt, w_stAcc, store_complete);
        w_gmCntNext = nextCount(r_gmCnt, w_grantGemm, gemm_complete);
        w_mlsWord   = {(mls_is_store ? 2'b10 : 2'b01), mls_rd, mls_addr};
        w_gemmWord  = {2'b11, gemm_new_weight, 3'b000, 16'd0,
                       gemm_rs1, gemm_rs2, gemm_rs3, gemm_rd};
    end

    always_comb begin
        w_set = '0;
        w_clr = '0;
        for (int i = 0; i < NUM_MAT; i++) begin
            w_set[i] = (w_ldAcc && (mls_rd == 4'(i))) ||
                       (w_grantGemm && (gemm_rd == 4'(i)));
            w_clr[i] = (load_complete && (load_complete_rd == 4'(i))) ||
                       (gemm_complete && (gemm_complete_rd == 4'(i)));
        end
    end

    // Drain status is computed from next-state values so it lines up with the counters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pendingWr <= '0;
            r_ldCnt     <= '0;
            r_stCnt     <= '0;
            r_gmCnt     <= '0;
            r_rrPrio    <= 1'b0;
            r_fifoWen   <= 1'b0;
            r_fifoWdata <= '0;
            r_drained   <= 1'b1;
        end else begin
            r_pendingWr <= (r_pendingWr & ~w_clr) | w_set;
            r_ldCnt     <= w_ldCntNext;
            r_stCnt     <= w_stCntNext;
            r_gmCnt     <= w_gmCntNext;
            if (w_canGrant && w_mlsCand && w_gemmCand)
                r_rrPrio <= ~r_rrPrio;
            r_fifoWen <= w_grantMls || w_grantGemm;
            if (w_grantMls)
                r_fifoWdata <= w_mlsWord;
            else if (w_grantGemm)
                r_fifoWdata <= w_gemmWord;
            r_drained <= (w_ldCntNext == '0) && (w_stCntNext == '0) &&
                         (w_gmCntNext == '0) && !(w_grantMls || w_grantGemm);
        end
    end

    assign mls_ready  = w_grantMls;
    assign gemm_ready = w_grantGemm;
    assign fifo_wen   = r_fifoWen;
    assign fifo_wdata = r_fifoWdata;
    assign drained    = r_drained;

endmodule

// File: tb/tb_sp_req_scheduler.sv
// Self-checking bench for sp_req_scheduler: a vector table, directed corner
// sequences and a randomized run against a set/count reference model.
module tb_sp_req_scheduler;

    logic        CLK, RST;
    logic        mls_valid, mls_is_store;
    logic [3:0]  mls_rd;
    logic [31:0] mls_addr;
    logic        mls_ready;
    logic        gemm_valid, gemm_new_weight;
    logic [3:0]  gemm_rs1, gemm_rs2, gemm_rs3, gemm_rd;
    logic        gemm_ready;
    logic        fifo_full, fifo_wen;
    logic [37:0] fifo_wdata;
    logic        load_complete, store_complete, gemm_complete;
    logic [3:0]  load_complete_rd, gemm_complete_rd;
    logic        halt, drained;

    int compared   = 0;
    int mismatched = 0;

    typedef struct packed {
        logic        mlsValid;
        logic        isStore;
        logic [3:0]  mlsRd;
        logic [31:0] addr;
        logic        gemmValid;
        logic        newW;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [3:0]  rs3;
        logic [3:0]  gRd;
        logic        full;
        logic        hlt;
        logic        ldC;
        logic        stC;
        logic        gmC;
        logic [3:0]  ldCRd;
        logic [3:0]  gmCRd;
        logic        expMlsReady;
        logic        expGemmReady;
        logic        expWen;
        logic [37:0] expWdata;
        logic        expDrained;
    } vec_t;

    vec_t vecs[12];

    sp_req_scheduler #(.MAX_OUTSTANDING(4), .NUM_MAT(16)) dut (
        .CLK(CLK), .RST(RST),
        .mls_valid(mls_valid), .mls_is_store(mls_is_store), .mls_rd(mls_rd),
        .mls_addr(mls_addr), .mls_ready(mls_ready),
        .gemm_valid(gemm_valid), .gemm_new_weight(gemm_new_weight),
        .gemm_rs1(gemm_rs1), .gemm_rs2(gemm_rs2), .gemm_rs3(gemm_rs3),
        .gemm_rd(gemm_rd), .gemm_ready(gemm_ready),
        .fifo_full(fifo_full), .fifo_wen(fifo_wen), .fifo_wdata(fifo_wdata),
        .load_complete(load_complete), .store_complete(store_complete),
        .gemm_complete(gemm_complete), .load_complete_rd(load_complete_rd),
        .gemm_complete_rd(gemm_complete_rd), .halt(halt), .drained(drained)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        mls_valid = 1'b0; mls_is_store = 1'b0; mls_rd = 4'd0; mls_addr = 32'd0;
        gemm_valid = 1'b0; gemm_new_weight = 1'b0;
        gemm_rs1 = 4'd0; gemm_rs2 = 4'd0; gemm_rs3 = 4'd0; gemm_rd = 4'd0;
        fifo_full = 1'b0; halt = 1'b0;
        load_complete = 1'b0; store_complete = 1'b0; gemm_complete = 1'b0;
        load_complete_rd = 4'd0; gemm_complete_rd = 4'd0;
    endtask

    task automatic applyStimulus(input vec_t v);
        mls_valid = v.mlsValid; mls_is_store = v.isStore; mls_rd = v.mlsRd;
        mls_addr = v.addr; gemm_valid = v.gemmValid; gemm_new_weight = v.newW;
        gemm_rs1 = v.rs1; gemm_rs2 = v.rs2; gemm_rs3 = v.rs3; gemm_rd = v.gRd;
        fifo_full = v.full; halt = v.hlt;
        load_complete = v.ldC; store_complete = v.stC; gemm_complete = v.gmC;
        load_complete_rd = v.ldCRd; gemm_complete_rd = v.gmCRd;
    endtask

    task automatic doReset(input string tag);
        idle();
        RST = 1'b1;
        tick();
        checkOutput({tag, "_wen"}, fifo_wen, 0);
        checkOutput({tag, "_wdata"}, fifo_wdata, 0);
        checkOutput({tag, "_drained"}, drained, 1);
        checkOutput({tag, "_ready"}, {mls_ready, gemm_ready}, 0);
        RST = 1'b0;
    endtask

    task automatic setLoad(input logic [3:0] rd, input logic [31:0] a);
        mls_valid = 1'b1; mls_is_store = 1'b0; mls_rd = rd; mls_addr = a;
    endtask

    task automatic setStore(input logic [3:0] rd, input logic [31:0] a);
        mls_valid = 1'b1; mls_is_store = 1'b1; mls_rd = rd; mls_addr = a;
    endtask

    task automatic setGemm(input logic nw, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] c, input logic [3:0] d);
        gemm_valid = 1'b1; gemm_new_weight = nw;
        gemm_rs1 = a; gemm_rs2 = b; gemm_rs3 = c; gemm_rd = d;
    endtask

    // Reference model state: pending destinations, in-flight counts, priority, last push.
    bit          mPend[16];
    int          mLd, mSt, mGm;
    bit          mRr;
    logic        mWen;
    logic [37:0] mWdata;
    int          ldQ[$];
    int          gmQ[$];

    task automatic randomRun(input int cycles);
        bit          eM, eG, mOk, gOk;
        logic [37:0] gWord;
        for (int i = 0; i < 16; i++) mPend[i] = 1'b0;
        mLd = 0; mSt = 0; mGm = 0; mRr = 1'b0; mWen = 1'b0; mWdata = '0;
        ldQ.delete(); gmQ.delete();
        for (int c = 0; c < cycles; c++) begin
            load_complete = 1'b0; store_complete = 1'b0; gemm_complete = 1'b0;
            if (ldQ.size() > 0 && $urandom_range(2) == 0) begin
                int k = $urandom_range(ldQ.size() - 1);
                load_complete = 1'b1; load_complete_rd = 4'(ldQ[k]); ldQ.delete(k);
            end
            if (gmQ.size() > 0 && $urandom_range(2) == 0) begin
                int k = $urandom_range(gmQ.size() - 1);
                gemm_complete = 1'b1; gemm_complete_rd = 4'(gmQ[k]); gmQ.delete(k);
            end
            if (mSt > 0 && $urandom_range(2) == 0) store_complete = 1'b1;
            else if (mSt == 0 && $urandom_range(15) == 0) store_complete = 1'b1;
            if (!mls_valid && $urandom_range(3) != 0) begin
                mls_valid = 1'b1; mls_is_store = 1'($urandom_range(1));
                mls_rd = 4'($urandom_range(15)); mls_addr = $urandom;
            end
            if (!gemm_valid && $urandom_range(3) != 0)
                setGemm(1'($urandom_range(1)), 4'($urandom_range(15)), 4'($urandom_range(15)),
                        4'($urandom_range(15)), 4'($urandom_range(15)));
            halt = ($urandom_range(7) == 0);
            fifo_full = ($urandom_range(4) == 0);
            #2;
            mOk = mls_valid && !mPend[mls_rd] && (mls_is_store ? (mSt < 4) : (mLd < 4));
            gOk = gemm_valid && !mPend[gemm_rs1] && !mPend[gemm_rs2] &&
                  !mPend[gemm_rs3] && !mPend[gemm_rd] && (mGm < 4);
            eM = 1'b0; eG = 1'b0;
            if (!halt && !fifo_full) begin
                if (mOk && gOk) begin
                    if (mRr) eG = 1'b1; else eM = 1'b1;
                    mRr = !mRr;
                end else begin
                    eM = mOk; eG = gOk;
                end
            end
            checkOutput("rnd_mls_ready", mls_ready, eM);
            checkOutput("rnd_gemm_ready", gemm_ready, eG);
            if (load_complete && mLd > 0) mLd--;
            if (store_complete && mSt > 0) mSt--;
            if (gemm_complete && mGm > 0) mGm--;
            if (load_complete) mPend[load_complete_rd] = 1'b0;
            if (gemm_complete) mPend[gemm_complete_rd] = 1'b0;
            gWord = {2'b11, gemm_new_weight, 3'b000, 16'd0, gemm_rs1, gemm_rs2, gemm_rs3, gemm_rd};
            mWen = eM || eG;
            if (eM) begin
                mWdata = {(mls_is_store ? 2'b10 : 2'b01), mls_rd, mls_addr};
                if (mls_is_store) mSt++;
                else begin mLd++; mPend[mls_rd] = 1'b1; ldQ.push_back(int'(mls_rd)); end
            end
            if (eG) begin
                mWdata = gWord; mGm++; mPend[gemm_rd] = 1'b1; gmQ.push_back(int'(gemm_rd));
            end
            tick();
            if (eM) mls_valid = 1'b0;
            if (eG) gemm_valid = 1'b0;
            checkOutput("rnd_wen", fifo_wen, mWen);
            checkOutput("rnd_wdata", fifo_wdata, mWdata);
            checkOutput("rnd_drained", drained, (mLd == 0 && mSt == 0 && mGm == 0 && !mWen));
        end
    endtask

    localparam logic [31:0] A0 = 32'h0000_1000;
    localparam logic [31:0] A1 = 32'h0000_2040;
    localparam logic [31:0] A2 = 32'hDEAD_BEEF;
    localparam logic [31:0] A3 = 32'h1234_5678;
    localparam logic [31:0] A4 = 32'h0000_0FFC;
    localparam logic [37:0] G0 = {2'b11, 4'b0000, 16'd0, 4'd2, 4'd3, 4'd4, 4'd6};
    localparam logic [37:0] G1 = {2'b11, 4'b1000, 16'd0, 4'd8, 4'd9, 4'd10, 4'd11};
    localparam logic [37:0] S1 = {2'b10, 4'd1, A0};
    localparam logic [37:0] S7 = {2'b10, 4'd7, A2};
    localparam logic [37:0] L11 = {2'b01, 4'd11, A4};

    initial begin
        // fields: mls(v,st,rd,addr) gemm(v,nw,rs1,rs2,rs3,rd) full halt ldC stC gmC ldCRd gmCRd | rdyM rdyG wen wdata drained
        vecs[0]  = '{1'b1,1'b1,4'd1,A0, 1'b1,1'b0,4'd2,4'd3,4'd4,4'd6, 1'b1,1'b0, 1'b0,1'b0,1'b0,4'd0,4'd0, 1'b0,1'b0,1'b0,38'd0,1'b1};
        vecs[1]  = vecs[0];
        vecs[2]  = vecs[0];
        vecs[3]  = '{1'b1,1'b1,4'd1,A0, 1'b1,1'b0,4'd2,4'd3,4'd4,4'd6, 1'b0,1'b0, 1'b0,1'b0,1'b0,4'd0,4'd0, 1'b1,1'b0,1'b1,S1,1'b0};
        vecs[4]  = '{1'b1,1'b1,4'd2,A1, 1'b1,1'b0,4'd2,4'd3,4'd4,4'd6, 1'b0,1'b0, 1'b0,1'b0,1'b0,4'd0,4'd0, 1'b0,1'b1,1'b1,G0,1'b0};
        vecs[5]  = '{1'b1,1'b1,4'd7,A2, 1'b1,1'b1,4'd8,4'd9,4'd10,4'd11, 1'b0,1'b0, 1'b0,1'b0,1'b0,4'd0,4'd0, 1'b1,1'b0,1'b1,S7,1'b0};
        vecs[6]  = '{1'b1,1'b1,4'd12,A3, 1'b1,1'b1,4'd8,4'd9,4'd10,4'd11, 1'b0,1'b0, 1'b0,1'b0,1'b0,4'd0,4'd0, 1'b0,1'b1,1'b1,G1,1'b0};
        vecs[7]  = '{1'b1,1'b1,4'd12,A3, 1'b1,1'b1,4'd8,4'd9,4'd10,4'd11, 1'b0,1'b1, 1'b0,1'b0,1'b0,4'd0,4'd0, 1'b0,1'b0,1'b0,G1,1'b0};
        vecs[8]  = '{1'b0,1'b0,4'd0,32'd0, 1'b0,1'b0,4'd0,4'd0,4'd0,4'd0, 1'b0,1'b0, 1'b0,1'b1,1'b1,4'd0,4'd6, 1'b0,1'b0,1'b0,G1,1'b0};
        vecs[9]  = '{1'b0,1'b0,4'd0,32'd0, 1'b0,1'b0,4'd0,4'd0,4'd0,4'd0, 1'b0,1'b0, 1'b0,1'b1,1'b1,4'd0,4'd11, 1'b0,1'b0,1'b0,G1,1'b1};
        vecs[10] = '{1'b1,1'b0,4'd11,A4, 1'b0,1'b0,4'd0,4'd0,4'd0,4'd0, 1'b0,1'b0, 1'b0,1'b1,1'b0,4'd0,4'd0, 1'b1,1'b0,1'b1,L11,1'b0};
        vecs[11] = '{1'b0,1'b0,4'd0,32'd0, 1'b0,1'b0,4'd0,4'd0,4'd0,4'd0, 1'b0,1'b0, 1'b1,1'b0,1'b0,4'd11,4'd0, 1'b0,1'b0,1'b0,L11,1'b1};

        RST = 1'b1;
        idle();
        #1;
        doReset("rst0");

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i]);
            #2;
            checkOutput($sformatf("vec%0d_mls_ready", i), mls_ready, vecs[i].expMlsReady);
            checkOutput($sformatf("vec%0d_gemm_ready", i), gemm_ready, vecs[i].expGemmReady);
            tick();
            checkOutput($sformatf("vec%0d_wen", i), fifo_wen, vecs[i].expWen);
            checkOutput($sformatf("vec%0d_wdata", i), fifo_wdata, vecs[i].expWdata);
            checkOutput($sformatf("vec%0d_drained", i), drained, vecs[i].expDrained);
        end

        // Single load, then a GEMM reading its destination is held until retirement.
        doReset("rst1");
        setLoad(4'd3, 32'h1000);
        #2 checkOutput("ld3_ready", mls_ready, 1);
        tick();
        mls_valid = 1'b0;
        checkOutput("ld3_wen", fifo_wen, 1);
        checkOutput("ld3_wdata", fifo_wdata, {2'b01, 4'd3, 32'h0000_1000});
        checkOutput("ld3_drained", drained, 0);
        setGemm(1'b0, 4'd0, 4'd0, 4'd3, 4'd9);
        #2 checkOutput("ld3_hazard_ready", gemm_ready, 0);
        tick();
        checkOutput("ld3_idle_wen", fifo_wen, 0);
        checkOutput("ld3_still_busy", drained, 0);
        load_complete = 1'b1; load_complete_rd = 4'd3;
        #2 checkOutput("ld3_same_cycle_ready", gemm_ready, 0);
        tick();
        load_complete = 1'b0;
        checkOutput("ld3_drained_after_cpl", drained, 1);
        #1 checkOutput("ld3_unblocked_ready", gemm_ready, 1);
        tick();
        gemm_valid = 1'b0;
        checkOutput("ld3_gemm_drained", drained, 0);
        gemm_complete = 1'b1; gemm_complete_rd = 4'd9;
        tick();
        gemm_complete = 1'b0;
        checkOutput("ld3_final_drained", drained, 1);

        // RAW hazard on rs2 with new weights.
        doReset("rst2");
        setLoad(4'd5, 32'h0000_0400);
        tick();
        mls_valid = 1'b0;
        setGemm(1'b1, 4'd1, 4'd5, 4'd2, 4'd7);
        #2 checkOutput("raw_held0", gemm_ready, 0);
        tick();
        #2 checkOutput("raw_held1", gemm_ready, 0);
        tick();
        load_complete = 1'b1; load_complete_rd = 4'd5;
        #2 checkOutput("raw_cpl_cycle", gemm_ready, 0);
        tick();
        load_complete = 1'b0;
        #2 checkOutput("raw_next_cycle", gemm_ready, 1);
        tick();
        gemm_valid = 1'b0;
        checkOutput("raw_wdata", fifo_wdata, {2'b11, 4'b1000, 16'd0, 4'd1, 4'd5, 4'd2, 4'd7});

        // Load limit: the fifth load waits for a retirement.
        doReset("rst3");
        for (int i = 0; i < 4; i++) begin
            setLoad(4'(i), 32'(i * 64));
            #2 checkOutput($sformatf("lim_ld%0d_ready", i), mls_ready, 1);
            tick();
        end
        setLoad(4'd4, 32'h100);
        #2 checkOutput("lim_ld4_stall0", mls_ready, 0);
        tick();
        load_complete = 1'b1; load_complete_rd = 4'd0;
        #2 checkOutput("lim_ld4_stall1", mls_ready, 0);
        tick();
        load_complete = 1'b0;
        #2 checkOutput("lim_ld4_ready", mls_ready, 1);
        tick();
        mls_valid = 1'b0;
        checkOutput("lim_ld4_wdata", fifo_wdata, {2'b01, 4'd4, 32'h100});

        // Halt with two stores outstanding.
        doReset("rst4");
        setStore(4'd1, 32'h10);
        tick();
        setStore(4'd2, 32'h20);
        tick();
        halt = 1'b1;
        setStore(4'd3, 32'h30);
        #2 checkOutput("halt_no_grant", mls_ready, 0);
        tick();
        checkOutput("halt_no_wen", fifo_wen, 0);
        store_complete = 1'b1;
        tick();
        checkOutput("halt_drained_after_1", drained, 0);
        tick();
        store_complete = 1'b0;
        checkOutput("halt_drained_after_2", drained, 1);
        #1 checkOutput("halt_still_blocked", mls_ready, 0);

        // Reset mid-stream forgets pending destinations and counts.
        doReset("rst5");
        setLoad(4'd9, 32'h90);
        tick();
        setLoad(4'd10, 32'hA0);
        tick();
        doReset("midrst");
        setLoad(4'd9, 32'h94);
        #2 checkOutput("midrst_ld9_ready", mls_ready, 1);
        tick();
        mls_valid = 1'b0;
        checkOutput("midrst_ld9_wdata", fifo_wdata, {2'b01, 4'd9, 32'h94});

        doReset("rst6");
        randomRun(3000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
